// File: rtl/frog_move_controller.sv
// ============================================================================
// Module      : frog_move_controller
// Description : Debounced four-button grid mover for the frog sprite. Moves
//               are applied only at frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frog_move_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int GRID_SIZE       = 32,
    parameter int COLS            = 20,
    parameter int ROWS            = 15,
    parameter int START_COL       = 10,
    parameter int START_ROW       = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic       frog_moved,
    output logic       frog_home
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [1:0] c_DIR_UP    = 2'd0;
    localparam logic [1:0] c_DIR_DOWN  = 2'd1;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        HOME    = 2'd2
    } state_t;

    logic [3:0] w_raw;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_deb;
    logic [3:0] r_deb_d;
    logic [3:0] w_press;

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_dir;
    logic [1:0] w_dir_next;
    logic [9:0] r_col;
    logic [9:0] r_row;
    logic [9:0] w_col_next;
    logic [9:0] w_row_next;
    logic       w_moved;
    logic       w_home;

    // Bit order: [0]=up [1]=down [2]=left [3]=right (also priority order)
    assign w_raw = {btn_right, btn_left, btn_down, btn_up};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb_d <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= w_deb;
        end
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_btn
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_deb;

            // Count consecutive samples that disagree with the accepted level;
            // any agreeing sample restarts the count.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (r_sync2[i] == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_cnt <= '0;
                    r_deb <= r_sync2[i];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_deb[i] = r_deb;
        end
    endgenerate

    assign w_press = w_deb & ~r_deb_d;

    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_col_next   = r_col;
        w_row_next   = r_row;
        w_moved      = 1'b0;
        w_home       = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_press) begin
                    w_state_next = PENDING;
                    if (w_press[0])      w_dir_next = c_DIR_UP;
                    else if (w_press[1]) w_dir_next = c_DIR_DOWN;
                    else if (w_press[2]) w_dir_next = c_DIR_LEFT;
                    else                 w_dir_next = c_DIR_RIGHT;
                end
            end
            PENDING: begin
                if (frame_tick) begin
                    w_state_next = IDLE;
                    case (r_dir)
                        c_DIR_UP: begin
                            if (r_row != 10'd0) begin
                                w_row_next = r_row - 10'd1;
                                w_moved    = 1'b1;
                            end
                        end
                        c_DIR_DOWN: begin
                            if (r_row != 10'(ROWS - 1)) begin
                                w_row_next = r_row + 10'd1;
                                w_moved    = 1'b1;
                            end
                        end
                        c_DIR_LEFT: begin
                            if (r_col != 10'd0) begin
                                w_col_next = r_col - 10'd1;
                                w_moved    = 1'b1;
                            end
                        end
                        default: begin
                            if (r_col != 10'(COLS - 1)) begin
                                w_col_next = r_col + 10'd1;
                                w_moved    = 1'b1;
                            end
                        end
                    endcase
                    if (w_moved && (w_row_next == 10'd0)) begin
                        w_home       = 1'b1;
                        w_state_next = HOME;
                    end
                end
            end
            HOME: begin
                if (frame_tick) begin
                    w_col_next   = 10'(START_COL);
                    w_row_next   = 10'(START_ROW);
                    w_moved      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dir      <= c_DIR_UP;
            r_col      <= 10'(START_COL);
            r_row      <= 10'(START_ROW);
            frog_x     <= 10'(START_COL * GRID_SIZE);
            frog_y     <= 10'(START_ROW * GRID_SIZE);
            frog_moved <= 1'b0;
            frog_home  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_dir      <= w_dir_next;
            r_col      <= w_col_next;
            r_row      <= w_row_next;
            frog_x     <= 10'(w_col_next * GRID_SIZE);
            frog_y     <= 10'(w_row_next * GRID_SIZE);
            frog_moved <= w_moved;
            frog_home  <= w_home;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_frog_move_controller.sv
// ============================================================================
// Module      : tb_frog_move_controller
// Description : Directed self-checking bench for frog_move_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frog_move_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic       frog_moved;
    logic       frog_home;

    int n_tests = 0;
    int n_fail  = 0;
    int n_moved = 0;
    int n_home  = 0;
    int n_both  = 0;

    frog_move_controller #(
        .DEBOUNCE_CYCLES(4),
        .GRID_SIZE      (32),
        .COLS           (20),
        .ROWS           (15),
        .START_COL      (10),
        .START_ROW      (14)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .frame_tick(frame_tick),
        .frog_x    (frog_x),
        .frog_y    (frog_y),
        .frog_moved(frog_moved),
        .frog_home (frog_home)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frog_moved) n_moved++;
        if (frog_home) n_home++;
        if (frog_moved && frog_home) n_both++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        cycle(2);
        reset = 1'b0;
        cycle(1);
        n_moved = 0;
        n_home  = 0;
        n_both  = 0;
    endtask

    // Drive a bitmask {right,left,down,up} high long enough to debounce, then release
    task automatic press(input logic [3:0] mask);
        {btn_right, btn_left, btn_down, btn_up} = mask;
        cycle(10);
        {btn_right, btn_left, btn_down, btn_up} = 4'b0000;
        cycle(10);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cycle(1);
        frame_tick = 1'b0;
        cycle(2);
    endtask

    initial begin
        // Reset values
        reset_dut();
        check("rst_x", frog_x, 320);
        check("rst_y", frog_y, 448);
        check("rst_moved", frog_moved, 0);
        check("rst_home", frog_home, 0);

        // Glitchy up press followed by a stable press: exactly one move
        btn_up = 1'b1; cycle(3);
        btn_up = 1'b0; cycle(1);
        btn_up = 1'b1; cycle(10);
        btn_up = 1'b0; cycle(10);
        check("glitch_no_move_before_tick", n_moved, 0);
        tick();
        check("glitch_y", frog_y, 416);
        check("glitch_x", frog_x, 320);
        check("glitch_moved_cnt", n_moved, 1);
        tick();
        check("glitch_single_move_y", frog_y, 416);
        check("glitch_single_move_cnt", n_moved, 1);

        // Simultaneous left+up: up wins; a later right press is ignored
        reset_dut();
        press(4'b0101);
        press(4'b1000);
        tick();
        check("prio_y", frog_y, 416);
        check("prio_x", frog_x, 320);
        tick();
        check("prio_ignored_x", frog_x, 320);
        check("prio_moved_cnt", n_moved, 1);

        // Down from bottom row is dropped; right presses clamp at column 19
        reset_dut();
        press(4'b0010);
        tick();
        check("drop_down_y", frog_y, 448);
        check("drop_down_moved", n_moved, 0);
        for (int i = 0; i < 10; i++) begin
            press(4'b1000);
            tick();
        end
        check("clamp_right_x", frog_x, 608);
        check("clamp_right_cnt", n_moved, 9);

        // Climb to row 0, then respawn
        reset_dut();
        for (int i = 0; i < 13; i++) begin
            press(4'b0001);
            tick();
        end
        check("climb_y13", frog_y, 32);
        check("climb_home_early", n_home, 0);
        press(4'b0001);
        tick();
        check("home_y", frog_y, 0);
        check("home_pulse", n_home, 1);
        check("home_with_moved", n_both, 1);
        press(4'b0010);
        tick();
        check("respawn_x", frog_x, 320);
        check("respawn_y", frog_y, 448);
        check("respawn_moved_cnt", n_moved, 15);
        check("respawn_no_home", n_home, 1);
        tick();
        check("after_home_idle_y", frog_y, 448);

        // Reset discards a pending move
        reset_dut();
        press(4'b0001);
        reset = 1'b1;
        cycle(1);
        reset = 1'b0;
        cycle(1);
        n_moved = 0;
        n_home  = 0;
        tick();
        check("pend_reset_x", frog_x, 320);
        check("pend_reset_y", frog_y, 448);
        check("pend_reset_moved", n_moved, 0);
        check("pend_reset_home", n_home, 0);

        // Button held through reset produces a fresh press afterwards
        reset_dut();
        btn_right = 1'b1;
        cycle(10);
        reset = 1'b1;
        cycle(2);
        reset = 1'b0;
        cycle(1);
        n_moved = 0;
        cycle(12);
        btn_right = 1'b0;
        cycle(10);
        tick();
        check("held_reset_x", frog_x, 352);
        check("held_reset_cnt", n_moved, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frog_move_controller.md
FROG_MOVE_CONTROLLER -- requirements
Module: frog_move_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles before a button level is accepted.
REQ-002 SHALL have parameter GRID_SIZE, default 32: pixels per grid step.
REQ-003 SHALL have parameters COLS, default 20, and ROWS, default 15: playfield size in cells (640x480).
REQ-004 SHALL have parameters START_COL, default 10, and START_ROW, default 14: spawn cell.
REQ-005 SHALL have port clk, input, 1: pixel clock; one clock, all logic on posedge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have ports btn_up, btn_down, btn_left, btn_right, input, 1 each: raw asynchronous buttons, active-high.
REQ-008 SHALL have port frame_tick, input, 1: one-cycle pulse at vsync start from the VGA timing.
REQ-009 SHALL have ports frog_x and frog_y, output, 10 each: frog top-left pixel position, registered.
REQ-010 SHALL have port frog_moved, output, 1: one-cycle pulse when a position change is applied.
REQ-011 SHALL have port frog_home, output, 1: one-cycle pulse when the frog reaches row 0.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-013 SHALL debounce each button independently: per-button counter restarts on any synchronized change; debounced level updates only after DEBOUNCE_CYCLES equal samples.
REQ-014 SHALL generate a press event on each debounced 0->1 transition only; holding a button generates no repeat.
REQ-015 SHALL use FSM states IDLE, PENDING, HOME.
REQ-016 IDLE: press event -> latch direction, go PENDING; simultaneous events resolved up > down > left > right.
REQ-017 PENDING: further press events ignored; on frame_tick apply latched move in that cycle, return IDLE.
REQ-018 Press event in IDLE coincident with frame_tick SHALL be latched and applied at the following frame_tick.
REQ-019 Move: up row-1, down row+1, left col-1, right col+1; frog_x = col*GRID_SIZE, frog_y = row*GRID_SIZE, 10-bit, no overflow for defaults.
REQ-020 Move leaving 0..COLS-1 or 0..ROWS-1 SHALL be dropped: position unchanged, no frog_moved, FSM returns IDLE.
REQ-021 Applied move SHALL update frog_x/frog_y and pulse frog_moved on the cycle after the frame_tick cycle.
REQ-022 Move into row 0 SHALL also pulse frog_home with frog_moved and go HOME instead of IDLE.
REQ-023 HOME: press events ignored; next frame_tick restores START_COL/START_ROW with one frog_moved pulse, no frog_home, then IDLE.
REQ-024 Outputs SHALL change only on the cycle following a frame_tick, never mid-frame.

Reset
REQ-025 reset SHALL force, on the next posedge: state IDLE, pending direction cleared, synchronizers, debounced levels and counters 0, frog_x=START_COL*GRID_SIZE (320), frog_y=START_ROW*GRID_SIZE (448), frog_moved=0, frog_home=0.
REQ-026 reset SHALL take priority over frame_tick and press events in the same cycle; a pending or HOME move SHALL be discarded.
REQ-027 A button held through reset release SHALL produce a press event after debounce (debounced level restarts from 0).

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset, release -> frog_x=320, frog_y=448, frog_moved=0, frog_home=0.
REQ-029 btn_up high 3 cycles with glitch then stable 10 cycles, frame_tick -> exactly one move, frog_y=416, one frog_moved pulse.
REQ-030 btn_left and btn_up debounced same cycle, frame_tick -> frog_y=416, frog_x=320 (up wins); second press before tick ignored.
REQ-031 From reset, btn_down press, frame_tick -> move dropped, frog_y=448, frog_moved stays 0; 10 right presses each followed by tick -> frog_x stops at 608.
REQ-032 14 up presses each followed by tick -> frog_y=0, frog_home and frog_moved pulse together; next frame_tick -> frog_x=320, frog_y=448, frog_moved pulse only.
REQ-033 Press latched in PENDING, reset asserted before frame_tick -> after tick, position remains 320/448, no pulses.
